// File: rtl/fft_frame_sink.sv
// fft_frame_sink
// Receives a streaming FFT output (one real sample per beat), rescales each
// sample by the frame's signed block exponent and buffers the result in a
// small FIFO that a consumer drains with a request/valid handshake.
//
// Build option: define FRAME_CHECK_EN to enable the sop/eop framing checker
// (IDLE/RUN/RESYNC FSM, beat counter, frame_err pulse and err_count).
// Without it every accepted beat is written, sop only latches the exponent,
// and frame_err/err_count read as zero.
//
// Ports:
//   clk, reset_n            single clock, asynchronous active-low reset
//   src_valid/sop/eop       FFT source beat qualifier and frame markers
//   src_real [15:0]         signed real sample
//   src_exp  [5:0]          signed block exponent, sampled on sop beats
//   src_ready               backpressure, high while the FIFO has room
//   out_req                 consumer pop request
//   out_data [15:0]         FIFO head (zero when empty)
//   out_valid               FIFO non-empty
//   underrun                one-cycle pulse after a request on an empty FIFO
//   frame_err               one-cycle pulse per framing error
//   err_count [7:0]         saturating framing error count
module fft_frame_sink #(
    parameter int FRAME_LEN  = 8192,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               src_valid,
    input  logic               src_sop,
    input  logic               src_eop,
    input  logic signed [15:0] src_real,
    input  logic signed [5:0]  src_exp,
    output logic               src_ready,
    input  logic               out_req,
    output logic [15:0]        out_data,
    output logic               out_valid,
    output logic               underrun,
    output logic               frame_err,
    output logic [7:0]         err_count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    logic [15:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNTW-1:0]   fifo_count;
    logic signed [5:0] exp_reg;
    logic signed [5:0] cur_exp;
    logic [15:0]       scaled;
    logic              accept;
    logic              wr_en;
    logic              push;
    logic              pop;

    // Block-exponent scaling. Negative exponents shift left in a wide signed
    // word so the result can be clamped to the 16-bit range afterwards.
    function automatic logic [15:0] scale(input logic signed [15:0] s,
                                          input logic signed [5:0]  e);
        logic signed [48:0] wide;
        logic [5:0]         n;
        wide = '0;
        n    = '0;
        if (e >= 6'sd16) begin
            return {16{s[15]}};
        end else if (e > 6'sd0) begin
            return s >>> e[3:0];
        end else if (e == 6'sd0) begin
            return s;
        end else begin
            n    = -e;
            wide = {{33{s[15]}}, s} <<< n;
            if (wide > 49'sd32767) begin
                return 16'h7FFF;
            end else if (wide < -49'sd32768) begin
                return 16'h8000;
            end else begin
                return wide[15:0];
            end
        end
    endfunction

    assign src_ready = fifo_count < CNTW'(FIFO_DEPTH);
    assign accept    = src_valid && src_ready;
    assign out_valid = fifo_count != '0;
    assign out_data  = out_valid ? mem[rd_ptr] : 16'h0000;
    assign pop       = out_req && out_valid;
    assign push      = accept && wr_en;

    // A sop beat is scaled by its own exponent, not the previous frame's.
    assign cur_exp = src_sop ? src_exp : exp_reg;
    assign scaled  = scale(src_real, cur_exp);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_reg <= '0;
        end else if (accept && src_sop) begin
            exp_reg <= src_exp;
        end
    end

    // FIFO storage carries no reset; out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= scaled;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            underrun   <= 1'b0;
        end else begin
            underrun <= out_req && !out_valid;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef FRAME_CHECK_EN
    typedef enum logic [1:0] {IDLE, RUN, RESYNC} state_t;

    localparam int BW = $clog2(FRAME_LEN + 1);

    state_t        state;
    state_t        next_state;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] next_cnt;
    logic [BW:0]   cnt_inc;
    logic          last_beat;
    logic          err_now;

    assign cnt_inc   = {1'b0, beat_cnt} + (BW+1)'(1);
    assign last_beat = cnt_inc == (BW+1)'(FRAME_LEN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= next_state;
            beat_cnt <= next_cnt;
        end
    end

    // A sop beat always (re)starts a frame from any state; a sop arriving
    // mid-frame is an error but the new frame is still kept.
    always_comb begin
        next_state = state;
        next_cnt   = beat_cnt;
        wr_en      = 1'b0;
        err_now    = 1'b0;
        if (accept) begin
            if (src_sop) begin
                wr_en    = 1'b1;
                next_cnt = BW'(1);
                if (state == RUN) begin
                    err_now = 1'b1;
                end
                if (src_eop) begin
                    next_state = IDLE;
                    if (FRAME_LEN != 1) begin
                        err_now = 1'b1;
                    end
                end else if (FRAME_LEN == 1) begin
                    next_state = RESYNC;
                    err_now    = 1'b1;
                end else begin
                    next_state = RUN;
                end
            end else begin
                case (state)
                    IDLE: begin
                        err_now = 1'b1;
                    end
                    RUN: begin
                        wr_en    = 1'b1;
                        next_cnt = cnt_inc[BW-1:0];
                        if (src_eop) begin
                            next_state = IDLE;
                            if (!last_beat) begin
                                err_now = 1'b1;
                            end
                        end else if (last_beat) begin
                            next_state = RESYNC;
                            err_now    = 1'b1;
                        end
                    end
                    RESYNC: begin
                        if (src_eop) begin
                            next_state = IDLE;
                        end
                    end
                    default: begin
                        next_state = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            frame_err <= err_now;
            if (err_now && err_count != 8'hFF) begin
                err_count <= err_count + 1'b1;
            end
        end
    end
`else
    logic unused_frame;

    assign wr_en        = 1'b1;
    assign frame_err    = 1'b0;
    assign err_count    = 8'h00;
    assign unused_frame = src_eop ^ (FRAME_LEN == 0);
`endif

endmodule

// File: tb/tb_fft_frame_sink.sv
// tb_fft_frame_sink
// Directed bench for fft_frame_sink with FRAME_LEN=8, FIFO_DEPTH=16.
// Expected samples are hand-computed and queued, then drained and compared.
// Framing expectations follow whether FRAME_CHECK_EN is defined.
module tb_fft_frame_sink;

    localparam int FL = 8;
    localparam int FD = 16;
`ifdef FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        src_valid;
    logic        src_sop;
    logic        src_eop;
    logic [15:0] src_real;
    logic [5:0]  src_exp;
    logic        src_ready;
    logic        out_req;
    logic [15:0] out_data;
    logic        out_valid;
    logic        underrun;
    logic        frame_err;
    logic [7:0]  err_count;

    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] expq[$];

    fft_frame_sink #(.FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .src_valid (src_valid),
        .src_sop   (src_sop),
        .src_eop   (src_eop),
        .src_real  (src_real),
        .src_exp   (src_exp),
        .src_ready (src_ready),
        .out_req   (out_req),
        .out_data  (out_data),
        .out_valid (out_valid),
        .underrun  (underrun),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One beat, presented for a single clock edge; returns #1 after that edge.
    task automatic applyStimulus(input logic sop, input logic eop,
                                 input logic [15:0] data, input logic [5:0] e);
        src_valid = 1'b1;
        src_sop   = sop;
        src_eop   = eop;
        src_real  = data;
        src_exp   = e;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        src_sop   = 1'b0;
        src_eop   = 1'b0;
    endtask

    task automatic drainCheck(input string tag);
        while (expq.size() > 0) begin
            checkOutput({tag, " valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, " data"}, 32'(out_data), 32'(expq.pop_front()));
            out_req = 1'b1;
            @(posedge clk);
            #1;
            out_req = 1'b0;
        end
        checkOutput({tag, " empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int          acc;
        logic        rdy;
        logic [15:0] v;

        reset_n   = 1'b0;
        src_valid = 1'b0;
        src_sop   = 1'b0;
        src_eop   = 1'b0;
        src_real  = '0;
        src_exp   = '0;
        out_req   = 1'b1;

        // Reset values, with a pop request held to show underrun stays low.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst out_data", 32'(out_data), 32'd0);
        checkOutput("rst src_ready", 32'(src_ready), 32'd1);
        checkOutput("rst underrun", 32'(underrun), 32'd0);
        checkOutput("rst frame_err", 32'(frame_err), 32'd0);
        checkOutput("rst err_count", 32'(err_count), 32'd0);
        out_req = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // exp=2 frame: 0x0400 >>> 2 = 0x0100, one-cycle latency on first beat.
        for (int i = 0; i < FL; i++) begin
            if (i == 0) checkOutput("lat before", 32'(out_valid), 32'd0);
            applyStimulus(i == 0, i == FL - 1, 16'h0400, 6'd2);
            if (i == 0) checkOutput("lat after", 32'(out_valid), 32'd1);
            checkOutput("f1 frame_err", 32'(frame_err), 32'd0);
            expq.push_back(16'h0100);
        end
        drainCheck("f1");

        // Negative exponent saturation, then exp>=16 sign fill.
        applyStimulus(1'b1, 1'b0, 16'h2000, 6'h3D);
        expq.push_back(16'h7FFF);
        applyStimulus(1'b0, 1'b0, 16'hE000, 6'h00);
        expq.push_back(16'h8000);
        for (int i = 2; i < FL - 1; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0001, 6'h00);
            expq.push_back(16'h0008);
        end
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 6'h00);
        expq.push_back(16'hFFF8);
        applyStimulus(1'b1, 1'b0, 16'h8000, 6'd20);
        expq.push_back(16'hFFFF);
        applyStimulus(1'b0, 1'b0, 16'h1234, 6'h00);
        expq.push_back(16'h0000);
        for (int i = 2; i < FL; i++) begin
            applyStimulus(1'b0, i == FL - 1, 16'h7FFF, 6'h00);
            expq.push_back(16'h0000);
        end
        checkOutput("sat err_count", 32'(err_count), 32'd0);
        drainCheck("sat");

        // Backpressure: no pops, 20 beats offered, only 16 fit.
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            src_valid = 1'b1;
            src_sop   = (i % FL) == 0;
            src_eop   = (i % FL) == FL - 1;
            src_real  = 16'(i);
            src_exp   = 6'd0;
            rdy       = src_ready;
            @(posedge clk);
            #1;
            if (rdy) acc++;
        end
        src_valid = 1'b0;
        src_sop   = 1'b0;
        src_eop   = 1'b0;
        checkOutput("bp accepted", 32'(acc), 32'd16);
        checkOutput("bp ready full", 32'(src_ready), 32'd0);
        checkOutput("bp head", 32'(out_data), 32'd0);
        out_req = 1'b1;
        @(posedge clk);
        #1;
        out_req = 1'b0;
        checkOutput("bp ready popped", 32'(src_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, 16'd16, 6'd0);
        checkOutput("bp ready refill", 32'(src_ready), 32'd0);
        for (int i = 1; i <= 16; i++) expq.push_back(16'(i));
        drainCheck("bp");
        for (int k = 1; k < FL; k++) begin
            applyStimulus(1'b0, k == FL - 1, 16'(100 + k), 6'd0);
            expq.push_back(16'(100 + k));
        end
        drainCheck("bp tail");
        checkOutput("bp err_count", 32'(err_count), 32'd0);

        // Early eop on beat 5, then a clean exp=1 frame.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i == 0, i == 4, 16'h0010, 6'd0);
            expq.push_back(16'h0010);
        end
        checkOutput("early frame_err", 32'(frame_err), FC ? 32'd1 : 32'd0);
        checkOutput("early err_count", 32'(err_count), FC ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        checkOutput("early pulse end", 32'(frame_err), 32'd0);
        for (int i = 0; i < FL; i++) begin
            v = 16'h0020 + 16'(i);
            applyStimulus(i == 0, i == FL - 1, v, 6'd1);
            checkOutput("clean frame_err", 32'(frame_err), 32'd0);
        end
        expq.push_back(16'h0010); expq.push_back(16'h0010);
        expq.push_back(16'h0011); expq.push_back(16'h0011);
        expq.push_back(16'h0012); expq.push_back(16'h0012);
        expq.push_back(16'h0013); expq.push_back(16'h0013);
        checkOutput("clean err_count", 32'(err_count), FC ? 32'd1 : 32'd0);
        drainCheck("early");

        // Pop request on an empty FIFO.
        out_req = 1'b1;
        checkOutput("ur before", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        out_req = 1'b0;
        checkOutput("ur pulse", 32'(underrun), 32'd1);
        checkOutput("ur out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("ur pulse end", 32'(underrun), 32'd0);

        // Reset mid-frame discards data and frame progress.
        applyStimulus(1'b1, 1'b0, 16'h0005, 6'd0);
        applyStimulus(1'b0, 1'b0, 16'h0006, 6'd0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mr out_valid", 32'(out_valid), 32'd0);
        checkOutput("mr out_data", 32'(out_data), 32'd0);
        checkOutput("mr src_ready", 32'(src_ready), 32'd1);
        checkOutput("mr err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0007, 6'd0);
        checkOutput("mr nonsop valid", 32'(out_valid), FC ? 32'd0 : 32'd1);
        checkOutput("mr nonsop err", 32'(frame_err), FC ? 32'd1 : 32'd0);
        checkOutput("mr nonsop count", 32'(err_count), FC ? 32'd1 : 32'd0);
        if (!FC) expq.push_back(16'h0007);
        drainCheck("mr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
